// File: rtl/collision_scan_engine.sv
// collision_scan_engine: walks every (shot, asteroid) slot pair, flags hits
// within a Chebyshev tolerance box and strobes clears for destroyed objects.
`timescale 1ns/1ps
module collision_scan_engine #(
   parameter int unsigned N_TIROS      = 4,
   parameter int unsigned N_ASTEROIDES = 8,
   parameter int unsigned COORD_W      = 4,
   parameter int unsigned HIT_TOL      = 0,
   parameter int unsigned PIERCE       = 0,
   localparam int unsigned TA_W = (N_TIROS > 1) ? $clog2(N_TIROS) : 1,
   localparam int unsigned AA_W = (N_ASTEROIDES > 1) ? $clog2(N_ASTEROIDES) : 1,
   localparam int unsigned HC_W = $clog2(N_TIROS * N_ASTEROIDES + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   output logic [TA_W-1:0]    tiro_addr,
   input  logic [COORD_W-1:0] tiro_x,
   input  logic [COORD_W-1:0] tiro_y,
   input  logic               tiro_valid,
   output logic [AA_W-1:0]    aste_addr,
   input  logic [COORD_W-1:0] aste_x,
   input  logic [COORD_W-1:0] aste_y,
   input  logic               aste_valid,
   output logic               clr_tiro,
   output logic               clr_aste,
   output logic               busy,
   output logic               done,
   output logic [HC_W-1:0]    hit_count,
   output logic [3:0]         db_estado
);

   localparam logic [TA_W-1:0] TI_LAST = TA_W'(N_TIROS - 1);
   localparam logic [AA_W-1:0] AI_LAST = AA_W'(N_ASTEROIDES - 1);
   localparam logic [HC_W-1:0] HC_MAX  = {HC_W{1'b1}};

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_INIT    = 4'd1,
      S_FETCH_T = 4'd2,
      S_EVAL_T  = 4'd3,
      S_FETCH_A = 4'd4,
      S_COMPARE = 4'd5,
      S_HIT     = 4'd6,
      S_NEXT_A  = 4'd7,
      S_NEXT_T  = 4'd8,
      S_DONE    = 4'd9
   } state_t;

   state_t state, state_next;

   logic [COORD_W-1:0] shot_x, shot_y;
   logic [COORD_W-1:0] dx_c, dy_c;
   logic               in_box_c;

   // Absolute distances without wrap: larger minus smaller.
   assign dx_c     = (aste_x >= shot_x) ? (aste_x - shot_x) : (shot_x - aste_x);
   assign dy_c     = (aste_y >= shot_y) ? (aste_y - shot_y) : (shot_y - aste_y);
   assign in_box_c = (32'(dx_c) <= HIT_TOL) && (32'(dy_c) <= HIT_TOL);

   assign db_estado = state;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic; unused codes fall back to IDLE.
   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:    state_next = start ? S_INIT : S_IDLE;
         S_INIT:    state_next = S_FETCH_T;
         S_FETCH_T: state_next = S_EVAL_T;
         S_EVAL_T:  state_next = tiro_valid ? S_FETCH_A : S_NEXT_T;
         S_FETCH_A: state_next = S_COMPARE;
         S_COMPARE: state_next = (aste_valid && in_box_c) ? S_HIT : S_NEXT_A;
         S_HIT:     state_next = (PIERCE != 0) ? S_NEXT_A : S_NEXT_T;
         S_NEXT_A:  state_next = (aste_addr == AI_LAST) ? S_NEXT_T : S_FETCH_A;
         S_NEXT_T:  state_next = (tiro_addr == TI_LAST) ? S_DONE : S_FETCH_T;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Status and strobe outputs, registered so they coincide with the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         clr_aste <= 1'b0;
         clr_tiro <= 1'b0;
      end else begin
         busy     <= (state_next != S_IDLE);
         done     <= (state_next == S_DONE);
         clr_aste <= (state_next == S_HIT);
         clr_tiro <= (state_next == S_HIT) && (PIERCE == 0);
      end
   end

   // Scan indices (driven straight onto the table addresses), shot capture, hit counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tiro_addr <= '0;
         aste_addr <= '0;
         shot_x    <= '0;
         shot_y    <= '0;
         hit_count <= '0;
      end else begin
         case (state)
            S_INIT: begin
               tiro_addr <= '0;
               aste_addr <= '0;
               hit_count <= '0;
            end
            S_EVAL_T: begin
               shot_x <= tiro_x;
               shot_y <= tiro_y;
               if (tiro_valid) aste_addr <= '0;
            end
            S_HIT: begin
               if (hit_count != HC_MAX) hit_count <= hit_count + HC_W'(1);
            end
            S_NEXT_A: begin
               if (aste_addr != AI_LAST) aste_addr <= aste_addr + AA_W'(1);
            end
            S_NEXT_T: begin
               if (tiro_addr != TI_LAST) tiro_addr <= tiro_addr + TA_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_scan_engine.sv
// Bench for collision_scan_engine: three instances (default, pierce, tolerance 1)
// share one synchronous-read table model; only the selected instance scans.
`timescale 1ns/1ps
module tb_collision_scan_engine;

   typedef struct {
      int               inst;
      logic [3:0]       tv;
      logic [3:0][7:0]  txy;   // per slot {x, y}
      logic [7:0]       av;
      logic [7:0][7:0]  axy;
      int               cyc;   // done cycle, counted from the start edge
      int               hits;
      int               nstb;
      logic [1:0][5:0]  stb;   // {clr_tiro, tiro_addr, aste_addr}
      int               max_aa;
   } vec_t;

   typedef struct {
      int cyc;
      int hits;
      int max_aa;
   } done_exp_t;

   logic clock, reset;
   logic start_v [3];
   logic [1:0] ta_w [3];
   logic [2:0] aa_w [3];
   logic       ct_w [3], ca_w [3], busy_w [3], done_w [3];
   logic [5:0] hc_w [3];
   logic [3:0] st_w [3];

   logic [1:0] sel;
   logic [1:0] ta_m;
   logic [2:0] aa_m;
   logic       ct_m, ca_m, busy_m, done_m;
   logic [5:0] hc_m;
   logic [3:0] st_m;

   logic [3:0][7:0] txy_t;
   logic [3:0]      tv_t;
   logic [7:0][7:0] axy_t;
   logic [7:0]      av_t;
   logic [3:0]      tclr;
   logic [7:0]      aclr;
   logic            load;
   logic [3:0]      tx_q, ty_q, ax_q, ay_q;
   logic            tv_q, av_q;

   int n_vec = 0;
   int n_err = 0;
   vec_t      vecs [7];
   done_exp_t dq [$];
   logic [5:0] sq [$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      collision_scan_engine #(
         .N_TIROS(4), .N_ASTEROIDES(8), .COORD_W(4),
         .HIT_TOL((g == 2) ? 1 : 0), .PIERCE((g == 1) ? 1 : 0)
      ) u_dut (
         .clock(clock), .reset(reset), .start(start_v[g]),
         .tiro_addr(ta_w[g]), .tiro_x(tx_q), .tiro_y(ty_q), .tiro_valid(tv_q),
         .aste_addr(aa_w[g]), .aste_x(ax_q), .aste_y(ay_q), .aste_valid(av_q),
         .clr_tiro(ct_w[g]), .clr_aste(ca_w[g]), .busy(busy_w[g]), .done(done_w[g]),
         .hit_count(hc_w[g]), .db_estado(st_w[g])
      );
   end

   assign ta_m   = ta_w[sel];
   assign aa_m   = aa_w[sel];
   assign ct_m   = ct_w[sel];
   assign ca_m   = ca_w[sel];
   assign busy_m = busy_w[sel];
   assign done_m = done_w[sel];
   assign hc_m   = hc_w[sel];
   assign st_m   = st_w[sel];

   // Object tables: one-cycle read latency, clear strobe written at the next edge.
   always @(posedge clock) begin
      if (load) begin
         tclr <= '0;
         aclr <= '0;
      end else begin
         if (ct_m) tclr[ta_m] <= 1'b1;
         if (ca_m) aclr[aa_m] <= 1'b1;
      end
      tx_q <= txy_t[ta_m][7:4];
      ty_q <= txy_t[ta_m][3:0];
      tv_q <= tv_t[ta_m] & ~tclr[ta_m];
      ax_q <= axy_t[aa_m][7:4];
      ay_q <= axy_t[aa_m][3:0];
      av_q <= av_t[aa_m] & ~aclr[aa_m];
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int inst, input logic [3:0] tv, input logic [31:0] txy,
                               input logic [7:0] av, input logic [63:0] axy, input int cyc,
                               input int hits, input int nstb, input logic [5:0] s0,
                               input logic [5:0] s1, input int max_aa);
      vec_t v;
      v.inst = inst; v.tv = tv; v.txy = txy; v.av = av; v.axy = axy;
      v.cyc = cyc; v.hits = hits; v.nstb = nstb; v.stb[0] = s0; v.stb[1] = s1;
      v.max_aa = max_aa;
      return v;
   endfunction

   task automatic load_tables(input vec_t v);
      sel   = 2'(v.inst);
      txy_t = v.txy;
      tv_t  = v.tv;
      axy_t = v.axy;
      av_t  = v.av;
      load  = 1'b1;
      @(negedge clock);
      load  = 1'b0;
   endtask

   task automatic pulse_start();
      start_v[sel] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start_v[sel] = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      done_exp_t d, e;
      logic [5:0] s;
      int cyc, maxaa, busy_low, lone_ct;
      bit got, prev_ca;
      load_tables(v);
      e.cyc = v.cyc; e.hits = v.hits; e.max_aa = v.max_aa;
      dq.push_back(e);
      for (int i = 0; i < v.nstb; i++) sq.push_back(v.stb[i]);
      pulse_start();
      cyc = 0; maxaa = 0; busy_low = 0; lone_ct = 0; got = 0; prev_ca = 0;
      while (!got && cyc < 400) begin
         if (cyc > 0 && int'(aa_m) > maxaa) maxaa = int'(aa_m);
         if (!busy_m) busy_low++;
         if (ct_m && !ca_m) lone_ct++;
         if (ca_m) begin
            check("strobe_width", int'(prev_ca), 0);
            if (sq.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
               s = sq.pop_front();
               check("strobe_clr_tiro", int'(ct_m), int'(s[5]));
               check("strobe_tiro_addr", int'(ta_m), int'(s[4:3]));
               check("strobe_aste_addr", int'(aa_m), int'(s[2:0]));
            end
         end
         prev_ca = ca_m;
         if (done_m) begin
            got = 1;
            d = dq.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("hit_count_at_done", int'(hc_m), d.hits);
            check("max_aste_addr", maxaa, d.max_aa);
         end else begin
            @(negedge clock);
            cyc++;
         end
      end
      if (!got) begin
         check("done_timeout", 0, 1);
         dq.delete();
      end
      check("strobes_missing", sq.size(), 0);
      sq.delete();
      check("busy_low_cycles", busy_low, 0);
      check("clr_tiro_without_aste", lone_ct, 0);
      @(negedge clock);
      check("done_one_cycle", int'(done_m), 0);
      check("idle_busy", int'(busy_m), 0);
      check("idle_state", int'(st_m), 0);
      check("hit_count_hold", int'(hc_m), v.hits);
   endtask

   initial begin
      int nd, dc, nstr;
      bit found;
      reset = 1'b1;
      load  = 1'b1;
      sel   = 2'd0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      txy_t = '0; tv_t = '0; axy_t = '0; av_t = '0;

      // asteroid k sits at (k,10) unless overridden
      vecs[0] = mk(0, 4'h0, 32'h0, 8'h00, 64'h0, 13, 0, 0, 6'h0, 6'h0, 0);
      vecs[1] = mk(0, 4'hF, 32'h30201000, 8'hFF, 64'h7A6A5A4A3A2A1A0A, 109, 0, 0, 6'h0, 6'h0, 7);
      vecs[2] = mk(0, 4'b0010, 32'h00005500, 8'hFF, 64'h7A555A4A3A2A1A0A, 34, 1, 1,
                   6'b1_01_110, 6'h0, 6);
      vecs[3] = mk(1, 4'b0001, 32'h00000033, 8'hFF, 64'h7A6A5A333A331A0A, 39, 2, 2,
                   6'b0_00_010, 6'b0_00_100, 7);
      vecs[4] = mk(2, 4'b0001, 32'h00000000, 8'b0000_0111, 64'h00000000001120F0, 22, 1, 1,
                   6'b1_00_010, 6'h0, 2);
      vecs[5] = mk(0, 4'b0011, 32'h00007777, 8'hFF, 64'h7A6A5A4A772A1A0A, 49, 1, 1,
                   6'b1_00_011, 6'h0, 7);
      vecs[6] = mk(0, 4'b1000, 32'h99000000, 8'hFF, 64'h996A5A4A3A2A1A0A, 37, 1, 1,
                   6'b1_11_111, 6'h0, 7);

      repeat (3) @(negedge clock);
      check("rst_busy", int'(busy_m), 0);
      check("rst_done", int'(done_m), 0);
      check("rst_hit_count", int'(hc_m), 0);
      check("rst_state", int'(st_m), 0);
      check("rst_tiro_addr", int'(ta_m), 0);
      check("rst_aste_addr", int'(aa_m), 0);
      check("rst_clr_tiro", int'(ct_m), 0);
      check("rst_clr_aste", int'(ca_m), 0);
      reset = 1'b0;
      load  = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset while comparing against the asteroid that would hit.
      load_tables(vecs[2]);
      pulse_start();
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (st_m == 4'd5 && aa_m == 3'd6) found = 1;
         else @(negedge clock);
      end
      check("reach_compare", int'(found), 1);
      #1 reset = 1'b1;
      #1;
      check("midrst_state", int'(st_m), 0);
      check("midrst_busy", int'(busy_m), 0);
      check("midrst_done", int'(done_m), 0);
      check("midrst_clr", int'(ct_m | ca_m), 0);
      check("midrst_hit_count", int'(hc_m), 0);
      check("midrst_tiro_addr", int'(ta_m), 0);
      check("midrst_aste_addr", int'(aa_m), 0);
      @(negedge clock);
      reset = 1'b0;
      nstr = 0;
      for (int c = 0; c < 6; c++) begin
         if (ct_m || ca_m) nstr++;
         @(negedge clock);
      end
      check("postrst_strobes", nstr, 0);
      check("postrst_state", int'(st_m), 0);

      // Start while busy (mid-scan and during DONE) must be ignored.
      load_tables(vecs[0]);
      pulse_start();
      nd = 0; dc = -1;
      for (int c = 0; c < 40; c++) begin
         if (done_m) begin
            nd++;
            if (nd == 1) dc = c;
         end
         start_v[0] = (c == 4 || c == 13);
         @(negedge clock);
      end
      start_v[0] = 1'b0;
      check("busy_start_done_count", nd, 1);
      check("busy_start_done_cycle", dc, 13);
      check("busy_start_final_state", int'(st_m), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
